// File: rtl/fp32_sqrt_rr_sched.sv
// fp32_sqrt_rr_sched: round-robin front end sharing one combinational fp32
// square-root datapath between NUM_REQ requesters, with a single registered
// result slot and a sticky IEEE-754 flag summary.

// Combinational fp32 square root, round-to-nearest-even.
// flags = {invalid, divzero, overflow, underflow, inexact}
module fp32_sqrt_comb (
  input  logic [31:0] a,
  output logic [31:0] y,
  output logic [4:0]  flags
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [7:0]        exp_a;
  logic [22:0]       frac_a;
  logic [23:0]       mant_n;
  logic signed [9:0] e_unb;
  logic signed [9:0] e_half;
  logic [24:0]       mant_m;
  logic [49:0]       rad;
  logic [24:0]       root;
  logic [27:0]       rem;
  logic [27:0]       trial;
  logic [24:0]       rnd;
  logic              guard;
  logic              sticky;
  logic              rnd_up;
  logic [7:0]        exp_y;
  logic [22:0]       frac_y;

  assign exp_a  = a[30:23];
  assign frac_a = a[22:0];

  // Normalise (including subnormals), make the exponent even, take the
  // integer root of the scaled mantissa, round, then override for specials.
  always_comb begin
    mant_n = {1'b1, frac_a};
    e_unb  = $signed({2'b00, exp_a}) - 10'sd127;
    if (exp_a == 8'd0) begin
      mant_n = {1'b0, frac_a};
      e_unb  = -10'sd126;
      for (int i = 0; i < 23; i++) begin
        if (!mant_n[23]) begin
          mant_n = mant_n << 1;
          e_unb  = e_unb - 10'sd1;
        end
      end
    end

    // Odd exponent: fold one factor of two into the mantissa (range [2,4)).
    if (e_unb[0]) begin
      mant_m = {mant_n, 1'b0};
      e_half = (e_unb - 10'sd1) >>> 1;
    end else begin
      mant_m = {1'b0, mant_n};
      e_half = e_unb >>> 1;
    end

    // 25 root bits: 24 significand bits plus one guard bit; remainder is sticky.
    rad  = {mant_m, 25'd0};
    rem  = '0;
    root = '0;
    for (int i = 24; i >= 0; i--) begin
      rem   = {rem[25:0], rad[2*i+1 -: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[23:0], 1'b1};
      end else begin
        root = {root[23:0], 1'b0};
      end
    end

    guard  = root[0];
    sticky = (rem != 28'd0);
    rnd_up = guard & (sticky | root[1]);
    rnd    = {1'b0, root[24:1]} + {24'd0, rnd_up};
    frac_y = rnd[24] ? rnd[23:1] : rnd[22:0];
    exp_y  = 8'(e_half + 10'sd127) + {7'd0, rnd[24]};

    y     = {1'b0, exp_y, frac_y};
    flags = {4'b0000, guard | sticky};

    if (exp_a == 8'hFF && frac_a != 23'd0) begin
      y     = QNAN;
      flags = frac_a[22] ? 5'b00000 : 5'b10000;
    end else if (exp_a == 8'd0 && frac_a == 23'd0) begin
      y     = a;
      flags = 5'b00000;
    end else if (a[31]) begin
      y     = QNAN;
      flags = 5'b10000;
    end else if (exp_a == 8'hFF) begin
      y     = a;
      flags = 5'b00000;
    end
  end
endmodule

module fp32_sqrt_rr_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int TAG_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_y,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [4:0]               rsp_flags,
  output logic [4:0]               sticky_flags,
  input  logic                     flag_clr
);
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             can_acc;
  logic             accept;
  logic             deliver;
  int               scan_idx;
  logic [31:0]      sel_a;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      sqrt_y;
  logic [4:0]       sqrt_flags;

  // Round-robin scan: first valid requester at or after ptr, wrapping.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(scan_idx);
      end
    end
  end

  assign can_acc   = !rsp_valid | rsp_ready;
  assign req_ready = (can_acc & gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign accept    = |(req_valid & req_ready);
  assign deliver   = rsp_valid & rsp_ready;
  assign sel_a     = gnt_any ? req_a[32*gnt_idx +: 32] : 32'd0;
  assign sel_tag   = gnt_any ? req_tag[TAG_W*gnt_idx +: TAG_W] : '0;

  fp32_sqrt_comb u_sqrt (
    .a     (sel_a),
    .y     (sqrt_y),
    .flags (sqrt_flags)
  );

  // Result slot and round-robin pointer: refill on accept, drain on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
      rsp_flags <= '0;
      ptr       <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_y     <= sqrt_y;
      rsp_id    <= gnt_idx;
      rsp_tag   <= sel_tag;
      rsp_flags <= sqrt_flags;
      ptr       <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (deliver) begin
      rsp_valid <= 1'b0;
    end
  end

  // Sticky summary: a delivery in the clear cycle still leaves its flags set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (flag_clr ? 5'd0 : sticky_flags) | (deliver ? rsp_flags : 5'd0);
    end
  end
endmodule

// File: tb/tb_fp32_sqrt_rr_sched.sv
// Bench for fp32_sqrt_rr_sched: directed scenarios followed by random traffic,
// all compared against a transaction-level model using real-number sqrt.
module tb_fp32_sqrt_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_a = '0;
  logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [31:0]              rsp_y;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic [4:0]               rsp_flags;
  logic [4:0]               sticky_flags;
  logic                     flag_clr = 1'b0;

  always #5 clk = ~clk;

  fp32_sqrt_rr_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_id       (rsp_id),
    .rsp_tag      (rsp_tag),
    .rsp_flags    (rsp_flags),
    .sticky_flags (sticky_flags),
    .flag_clr     (flag_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference state of the block at transaction level.
  bit          m_valid;
  logic [31:0] m_y;
  logic [4:0]  m_fl;
  int          m_id;
  logic [3:0]  m_tag;
  int          m_ptr;
  logic [4:0]  m_sticky;

  logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0001, 32'h3F80_0000};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Square root from IEEE rules: specials by case, finite values via a
  // double-precision sqrt then RNE rounding to 24 significand bits.
  function automatic void ref_sqrt(input logic [31:0] a, output logic [31:0] y, output logic [4:0] fl);
    logic [7:0]  e;
    logic [22:0] f;
    real         v;
    real         r;
    logic [63:0] b;
    logic [23:0] m;
    logic        half;
    logic        rest;
    int          ex;
    e  = a[30:23];
    f  = a[22:0];
    fl = 5'b00000;
    if (e == 8'hFF && f != 0) begin
      y  = 32'h7FC0_0000;
      fl = f[22] ? 5'b00000 : 5'b10000;
      return;
    end
    if (e == 8'd0 && f == 0) begin y = a; return; end
    if (a[31]) begin y = 32'h7FC0_0000; fl = 5'b10000; return; end
    if (e == 8'hFF) begin y = a; return; end
    if (e == 8'd0) v = real'(f) * $bitstoreal(64'h36A0_0000_0000_0000);
    else           v = $bitstoreal({1'b0, 11'(int'(e) + 896), f, 29'd0});
    r    = $sqrt(v);
    b    = $realtobits(r);
    ex   = int'(b[62:52]) - 1023 + 127;
    m    = {1'b1, b[51:29]};
    half = b[28];
    rest = |b[27:0];
    if (half && (rest || m[0])) begin
      m = m + 24'd1;
      if (m == 24'd0) ex = ex + 1;
    end
    y  = {1'b0, 8'(ex), m[22:0]};
    fl = {4'b0000, half | rest};
  endfunction

  function automatic logic [31:0] rand_op();
    int c;
    c = $urandom_range(0, 9);
    case (c)
      0:       return specials[$urandom_range(0, 7)];
      1:       return {1'b0, 8'd0, 23'($urandom)};
      2:       return {1'b1, 8'($urandom_range(0, 254)), 23'($urandom)};
      default: return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_y      = '0;
    m_fl     = '0;
    m_id     = 0;
    m_tag    = '0;
    m_ptr    = 0;
    m_sticky = '0;
  endtask

  // One clock: check the grant ahead of the edge, advance the model,
  // then compare every registered output just after the edge.
  task automatic cycle();
    int          g;
    logic [3:0]  exp_ready;
    logic [4:0]  n_sticky;
    logic [31:0] ey;
    logic [4:0]  ef;
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    exp_ready = ((!m_valid || rsp_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    n_sticky = (flag_clr ? 5'd0 : m_sticky) | ((m_valid && rsp_ready) ? m_fl : 5'd0);
    if (exp_ready != 0) begin
      ref_sqrt(req_a[32*g +: 32], ey, ef);
      m_valid = 1'b1;
      m_y     = ey;
      m_fl    = ef;
      m_id    = g;
      m_tag   = req_tag[TAG_W*g +: TAG_W];
      m_ptr   = (g + 1) % NUM_REQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    m_sticky = n_sticky;
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_y", rsp_y, m_y);
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
    chk("rsp_flags", 32'(rsp_flags), 32'(m_fl));
    chk("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic mid_reset();
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] tag);
    req_a[32*i +: 32]       = a;
    req_tag[TAG_W*i +: TAG_W] = tag;
  endtask

  logic [31:0] held_y;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("init_rsp_y", rsp_y, 32'd0);
    chk("init_rsp_id", 32'(rsp_id), 32'd0);
    chk("init_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("init_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("init_sticky", 32'(sticky_flags), 32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // sqrt(4.0) from requester 2 alone
    rsp_ready = 1'b1;
    set_req(2, 32'h4080_0000, 4'd5);
    req_valid = 4'b0100;
    cycle();
    chk("t1_y", rsp_y, 32'h4000_0000);
    chk("t1_id", 32'(rsp_id), 32'd2);
    chk("t1_tag", 32'(rsp_tag), 32'd5);
    chk("t1_flags", 32'(rsp_flags), 32'd0);

    // inexact then invalid, sticky accumulates both
    set_req(0, 32'h4000_0000, 4'd6);
    req_valid = 4'b0001;
    cycle();
    chk("t2_sqrt2_y", rsp_y, 32'h3FB5_04F3);
    chk("t2_sqrt2_flags", 32'(rsp_flags), 32'b00001);
    set_req(3, 32'hBF80_0000, 4'd7);
    req_valid = 4'b1000;
    cycle();
    chk("t2_neg_y", rsp_y, 32'h7FC0_0000);
    chk("t2_neg_flags", 32'(rsp_flags), 32'b10000);
    req_valid = 4'b0000;
    cycle();
    chk("t2_sticky", 32'(sticky_flags), 32'b10001);

    // all requesters busy, consumer always ready: 0,1,2,3,0
    set_req(0, 32'h3F80_0000, 4'd8);
    set_req(1, 32'h4080_0000, 4'd9);
    set_req(2, 32'h4110_0000, 4'd10);
    set_req(3, 32'h4180_0000, 4'd11);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_order", 32'(rsp_id), 32'(k % 4));
      chk("t3_valid", 32'(rsp_valid), 32'd1);
    end
    chk("t3_last_y", rsp_y, 32'h3F80_0000);

    // back-pressure for three cycles, then drain and refill together
    rsp_ready = 1'b0;
    held_y = rsp_y;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      chk("t4_stall_y", rsp_y, held_y);
      chk("t4_stall_id", 32'(rsp_id), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_release_ready", 32'(req_ready), 32'b0010);
    cycle();
    chk("t4_next_id", 32'(rsp_id), 32'd1);
    chk("t4_next_y", rsp_y, 32'h4000_0000);

    // clear in the same cycle as an inexact delivery
    set_req(2, 32'h4000_0000, 4'd3);
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    cycle();
    chk("t5_pre_sticky", 32'(sticky_flags), 32'b10001);
    rsp_ready = 1'b1;
    flag_clr  = 1'b1;
    cycle();
    flag_clr = 1'b0;
    chk("t5_sticky", 32'(sticky_flags), 32'b00001);

    // reset while a result is held
    set_req(0, 32'h4080_0000, 4'd1);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    cycle();
    chk("t6_held", 32'(rsp_valid), 32'd1);
    mid_reset();
    rsp_ready = 1'b1;
    set_req(1, 32'h4110_0000, 4'd2);
    set_req(3, 32'h4180_0000, 4'd4);
    req_valid = 4'b1010;
    cycle();
    chk("t6_first_id", 32'(rsp_id), 32'd1);
    chk("t6_first_y", rsp_y, 32'h4040_0000);

    // random traffic with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), 4'($urandom));
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 15) == 0);
      if (n == 300) mid_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
